// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one single-port memory between the
// instruction-fetch port (read-only) and the data port (read/write).
// One access at a time: IDLE -> ISSUE -> [WAIT x READ_LATENCY] -> ACK -> IDLE.
// Every output is a register; nothing combinational reaches the ports.
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_write,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_mode,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // Wait counter only needs to reach READ_LATENCY-1.
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LATENCY - 1);

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic          last_grant;  // port served most recently
  logic          grant;       // port owning the access in flight
  logic          is_write;    // access in flight is a write
  logic [CW-1:0] wait_count;
  logic          pick_data;

  // Data wins when it is the only requester, or on a tie when fetch went last.
  assign pick_data = data_req & (~fetch_req | (last_grant == GRANT_FETCH));

  // Arbitration FSM with all port-facing outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_DATA;   // fetch wins the first tie
      grant       <= GRANT_FETCH;
      is_write    <= 1'b0;
      wait_count  <= '0;
      fetch_ack   <= 1'b0;
      fetch_rdata <= '0;
      data_ack    <= 1'b0;
      data_rdata  <= '0;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_mode    <= 1'b0;
      mem_data_in <= '0;
    end else begin
      // Acks are single-cycle pulses; they are re-raised only on entry to ACK.
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            grant      <= pick_data;
            last_grant <= pick_data;
            if (pick_data) begin
              mem_address <= data_addr;
              mem_mode    <= data_write;
              mem_data_in <= data_wdata;
              is_write    <= data_write;
            end else begin
              // Fetch is read-only; mem_data_in keeps its last value.
              mem_address <= fetch_addr;
              mem_mode    <= 1'b0;
              is_write    <= 1'b0;
            end
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples at the closing edge of this single cycle.
          mem_mode   <= 1'b0;
          wait_count <= '0;
          if (is_write) begin
            if (grant == GRANT_DATA) data_ack  <= 1'b1;
            else                     fetch_ack <= 1'b1;
            state <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_count == LAST_WAIT) begin
            if (grant == GRANT_DATA) begin
              data_rdata <= mem_data_out;
              data_ack   <= 1'b1;
            end else begin
              fetch_rdata <= mem_data_out;
              fetch_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: drives fetch/data requests (directed cases, then random
// rounds) into memory_arbiter attached to a behavioural latency-pipelined
// memory. The driver predicts each response from a word-array reference and
// round-robin rule and queues it; a monitor pops and compares on every ack.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_req, data_req, data_write;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic          fetch_ack, data_ack, busy, mem_mode;
  logic [DW-1:0] fetch_rdata, data_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_address;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_write(data_write), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata), .busy(busy),
    .mem_address(mem_address), .mem_mode(mem_mode), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memory: writes dropped and reads 0 outside DEPTH, RL-deep read pipe.
  logic          pre_we = 1'b0;
  logic [6:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem_array [0:DEPTH-1];
  logic [DW-1:0] pipe [0:RL-1];
  always @(posedge clock) begin
    if (pre_we) mem_array[pre_addr] <= pre_data;
    else if (mem_mode && mem_address < DEPTH) mem_array[mem_address[6:0]] <= mem_data_in;
    pipe[0] <= (mem_address < DEPTH) ? mem_array[mem_address[6:0]] : '0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_out = pipe[RL-1];

  typedef struct {
    bit            port;  // 0 fetch, 1 data
    bit            wr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            last_grant = 1'b1;
  int            mode_cycles = 0;
  logic [DW-1:0] last_rdata [0:1];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every ack and checks port, timing and data.
  always @(negedge clock) begin
    if (!reset_n) begin
      last_rdata[0] = '0;
      last_rdata[1] = '0;
    end else begin
      if (mem_mode) mode_cycles++;
      if (fetch_ack || data_ack) begin
        exp_t e;
        check("single_ack", {63'b0, fetch_ack & data_ack}, 64'd0);
        if (sbq.size() == 0) begin
          check("unexpected_ack", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("ack_port", {63'b0, data_ack}, {63'b0, e.port});
          check("ack_cycle", cyc, e.cyc);
          check("busy_at_ack", {63'b0, busy}, 64'd1);
          if (!e.wr) last_rdata[e.port] = e.data;
          check("fetch_rdata", fetch_rdata, last_rdata[0]);
          check("data_rdata", data_rdata, last_rdata[1]);
        end
      end
    end
  end

  // One arbitration round: requests raised together at c0 and held until acked.
  task automatic do_round(input bit f, input bit d, input logic [AW-1:0] fa,
                          input logic [AW-1:0] da, input bit dw, input logic [DW-1:0] wd);
    int            t, n, seen;
    bit            order [0:1];
    bit            fa_s, da_s;
    logic [AW-1:0] a;
    exp_t          e;
    fetch_req = f; fetch_addr = fa;
    data_req = d; data_addr = da; data_write = dw; data_wdata = wd;
    n = 0;
    order[0] = 1'b0; order[1] = 1'b1;
    if (f && d) begin
      order[0] = ~last_grant; order[1] = last_grant; n = 2;
    end else if (f || d) begin
      order[0] = d; n = 1;
    end
    t = cyc;
    for (int k = 0; k < n; k++) begin
      e.port = order[k];
      e.wr = order[k] & dw;
      if (e.wr) begin
        if (da < DEPTH) ref_mem[da[6:0]] = wd;
        e.data = '0;
      end else begin
        a = order[k] ? da : fa;
        e.data = (a < DEPTH) ? ref_mem[a[6:0]] : '0;
      end
      e.cyc = t + (e.wr ? 2 : 2 + RL);
      t = e.cyc + 1;
      last_grant = order[k];
      sbq.push_back(e);
    end
    seen = 0;
    for (int w = 0; w < 60 && seen < n; w++) begin
      @(negedge clock);
      if (fetch_ack || data_ack) begin
        fa_s = fetch_ack; da_s = data_ack;
        @(posedge clock); #1;
        if (fa_s) fetch_req = 1'b0;
        if (da_s) data_req = 1'b0;
        seen += int'(fa_s) + int'(da_s);
      end
    end
    if (seen < n) begin
      check("ack_timeout", seen, n);
      sbq.delete();
      fetch_req = 1'b0; data_req = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; #1;
    check("rst_fetch_ack", {63'b0, fetch_ack}, 64'd0);
    check("rst_data_ack", {63'b0, data_ack}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_mem_mode", {63'b0, mem_mode}, 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_data_in", mem_data_in, 64'd0);
    check("rst_fetch_rdata", fetch_rdata, 64'd0);
    check("rst_data_rdata", data_rdata, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    last_grant = 1'b1;
    sbq.delete();
  endtask

  initial begin
    int m0;
    fetch_req = 0; data_req = 0; data_write = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    // Preload memory while the arbiter is held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      pre_we = 1'b1;
      pre_addr = 7'(i);
      pre_data = (i == 0) ? 32'h1003c1e0 : ((i == 61) ? 32'h0 : $urandom);
      ref_mem[i] = pre_data;
      @(posedge clock); #1;
    end
    pre_we = 1'b0;
    do_reset();

    // Fetch read of word 0.
    do_round(1, 0, 0, 0, 0, 0);
    // Data write then read-back of word 60; mem_mode must pulse for one cycle.
    m0 = mode_cycles;
    do_round(0, 1, 0, 60, 1, 32'hDEADBEEF);
    check("write_mode_pulse", mode_cycles - m0, 1);
    do_round(0, 1, 0, 60, 0, 0);

    // Simultaneous requests after reset: fetch first, then alternation.
    do_reset();
    repeat (3) do_round(1, 1, $urandom_range(0, 127), $urandom_range(0, 127), 0, 0);
    do_round(1, 1, 5, 7, 1, 32'hCAFE0007);

    // Reset in the ISSUE cycle of a write to word 61.
    data_req = 1; data_addr = 61; data_write = 1; data_wdata = 32'h5555AAAA;
    @(posedge clock); #1;
    check("issue_mode_high", {63'b0, mem_mode}, 64'd1);
    #2 reset_n = 1'b0; #1;
    check("abort_mode_low", {63'b0, mem_mode}, 64'd0);
    check("abort_busy_low", {63'b0, busy}, 64'd0);
    check("abort_no_ack", {62'b0, fetch_ack, data_ack}, 64'd0);
    data_req = 0; data_write = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    last_grant = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    do_round(0, 1, 0, 61, 0, 0);

    // Out-of-range read returns 0; out-of-range write is dropped.
    do_round(0, 1, 0, 200, 0, 0);
    do_round(0, 1, 0, 200, 1, 32'h12345678);
    do_round(1, 0, 200, 0, 0, 0);

    // Random rounds.
    for (int r = 0; r < 300; r++) begin
      bit f, d;
      f = 1'($urandom);
      d = 1'($urandom);
      if (f || d)
        do_round(f, d, $urandom_range(0, 159), $urandom_range(0, 159), 1'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    repeat (5) @(posedge clock);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
